// File: rtl/fifo_serial_pkg.sv
// rtl/fifo_serial_pkg.sv - shared types and sizing helpers for the FIFO serial drain
package fifo_serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    function automatic int frame_bits(input int data_w, input int parity_en);
        return 2 + data_w + parity_en;
    endfunction

    function automatic int timer_w(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - free-running bit-period counter with synchronous clear and terminal tick
module bit_timer
    import fifo_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic clr,
    output logic tick
);

    localparam int TW = timer_w(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/fifo_serial_drain.sv
// rtl/fifo_serial_drain.sv - pops FIFO words and sends each as a start/data/parity/stop serial frame
module fifo_serial_drain
    import fifo_serial_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              EN,
    input  logic              EMPTY,
    output logic              RD,
    input  logic [DATA_W-1:0] dataOut,
    output logic              txSerial,
    output logic              busy,
    output logic              frameDone
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            r_state;
    logic              r_rd;
    logic              r_tx;
    logic              r_done;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic [BW-1:0]     r_bit;

    logic w_tick;
    logic w_clr;

    // Timer is held at zero until the frame starts, so START gets a full bit period.
    assign w_clr = (r_state == IDLE) || (r_state == FETCH) || (r_state == LATCH);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .clr  (w_clr),
        .tick (w_tick)
    );

    // The line register follows the state one cycle later, so the frame on the wire
    // and frameDone line up with each other.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
            r_rd    <= 1'b0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_bit   <= '0;
        end else begin
            r_rd   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (EN && !EMPTY) begin
                        r_rd    <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    r_tx    <= 1'b1;
                    r_state <= LATCH;
                end
                LATCH: begin
                    r_tx    <= 1'b1;
                    r_shift <= dataOut;
                    r_par   <= ^dataOut;
                    r_bit   <= '0;
                    r_state <= START;
                end
                START: begin
                    r_tx <= 1'b0;
                    if (w_tick) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    r_tx <= r_shift[0];
                    if (w_tick) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit == LAST_BIT) begin
                            r_bit   <= '0;
                            r_state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    r_tx <= r_par;
                    if (w_tick) begin
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    r_tx <= 1'b1;
                    if (w_tick) begin
                        r_done <= 1'b1;
                        if (EN && !EMPTY) begin
                            r_rd    <= 1'b1;
                            r_state <= FETCH;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign RD        = r_rd;
    assign txSerial  = r_tx;
    assign frameDone = r_done;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_serial_drain.sv
// tb/tb_fifo_serial_drain.sv - self-checking bench for fifo_serial_drain against a frame-level model
module tb_fifo_serial_drain;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       en0 = 1'b0, en1 = 1'b0;
    logic       empty0, empty1;
    logic       rd0, rd1;
    logic [3:0] dout0 = '0, dout1 = '0;
    logic       tx0, tx1, busy0, busy1, done0, done1;

    logic [3:0] mem0 [0:63];
    logic [3:0] mem1 [0:63];
    int pushed0 = 0, popped0 = 0, pushed1 = 0, popped1 = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign empty0 = (pushed0 == popped0);
    assign empty1 = (pushed1 == popped1);

    // FIFO model: word appears on dataOut in the cycle after RD.
    always @(posedge clk) begin
        if (rd0) begin
            dout0   <= mem0[popped0[5:0]];
            popped0 <= popped0 + 1;
        end
        if (rd1) begin
            dout1   <= mem1[popped1[5:0]];
            popped1 <= popped1 + 1;
        end
    end

    fifo_serial_drain #(.DATA_W(4), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut0 (
        .Clk(clk), .Rst_n(rst_n), .EN(en0), .EMPTY(empty0), .RD(rd0), .dataOut(dout0),
        .txSerial(tx0), .busy(busy0), .frameDone(done0)
    );

    fifo_serial_drain #(.DATA_W(4), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut1 (
        .Clk(clk), .Rst_n(rst_n), .EN(en1), .EMPTY(empty1), .RD(rd1), .dataOut(dout1),
        .txSerial(tx1), .busy(busy1), .frameDone(done1)
    );

    function automatic logic tx_of(input int inst);
        return (inst != 0) ? tx1 : tx0;
    endfunction

    function automatic logic rd_of(input int inst);
        return (inst != 0) ? rd1 : rd0;
    endfunction

    function automatic logic done_of(input int inst);
        return (inst != 0) ? done1 : done0;
    endfunction

    function automatic logic busy_of(input int inst);
        return (inst != 0) ? busy1 : busy0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int inst, input logic [3:0] d);
        if (inst != 0) begin
            mem1[pushed1[5:0]] = d;
            pushed1 = pushed1 + 1;
        end else begin
            mem0[pushed0[5:0]] = d;
            pushed0 = pushed0 + 1;
        end
    endtask

    task automatic wait_rd(input int inst);
        int n;
        n = 0;
        while (rd_of(inst) !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rd_seen_in_time", 32'(n < 200), 32'd1);
    endtask

    // Entered at the negedge where RD is seen; leaves at the negedge of the last stop cycle.
    task automatic check_frame(input int inst, input logic [3:0] d, input int pe, input int drop_at);
        int bits [0:7];
        int nb;
        nb = 0;
        bits[nb] = 0; nb++;
        for (int i = 0; i < 4; i++) begin
            bits[nb] = int'(d[i]); nb++;
        end
        if (pe != 0) begin
            bits[nb] = $countones(d) % 2; nb++;
        end
        bits[nb] = 1; nb++;
        chk("pre_line_high", 32'(tx_of(inst)), 32'd1);
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            chk("gap_line_high", 32'(tx_of(inst)), 32'd1);
            chk("gap_rd_low", 32'(rd_of(inst)), 32'd0);
            chk("gap_busy", 32'(busy_of(inst)), 32'd1);
        end
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < CPB; j++) begin
                @(negedge clk);
                if (b * CPB + j == drop_at) en0 = 1'b0;
                chk($sformatf("frame_bit%0d", b), 32'(tx_of(inst)), 32'(bits[b]));
                chk("frame_done", 32'(done_of(inst)), 32'((b == nb - 1) && (j == CPB - 1)));
                if (!((b == nb - 1) && (j == CPB - 1)))
                    chk("frame_rd_low", 32'(rd_of(inst)), 32'd0);
            end
        end
    endtask

    initial begin
        logic [3:0] w [0:3];
        int rd_seen;
        int tx_low;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx0), 32'd1);
        chk("rst_rd", 32'(rd0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_tx_np", 32'(tx1), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word 0xA
        en0 = 1'b1;
        push(0, 4'hA);
        wait_rd(0);
        check_frame(0, 4'hA, 1, -1);
        chk("single_rd_end", 32'(rd0), 32'd0);
        chk("single_busy_end", 32'(busy0), 32'd0);
        @(negedge clk);
        chk("single_done_pulse", 32'(done0), 32'd0);
        chk("single_idle_tx", 32'(tx0), 32'd1);

        // Back-to-back 0x1, 0x7
        push(0, 4'h1);
        push(0, 4'h7);
        wait_rd(0);
        check_frame(0, 4'h1, 1, -1);
        chk("b2b_second_rd", 32'(rd0), 32'd1);
        check_frame(0, 4'h7, 1, -1);
        chk("b2b_rd_end", 32'(rd0), 32'd0);
        chk("b2b_busy_end", 32'(busy0), 32'd0);

        // Random back-to-back words
        for (int i = 0; i < 3; i++) begin
            w[i] = 4'($urandom);
            push(0, w[i]);
        end
        wait_rd(0);
        for (int i = 0; i < 3; i++) begin
            check_frame(0, w[i], 1, -1);
            chk("rand_next_rd", 32'(rd0), 32'(i < 2));
        end
        chk("rand_busy_end", 32'(busy0), 32'd0);

        // No parity, data 0xF
        en1 = 1'b1;
        push(1, 4'hF);
        wait_rd(1);
        check_frame(1, 4'hF, 0, -1);
        chk("np_rd_end", 32'(rd1), 32'd0);
        chk("np_busy_end", 32'(busy1), 32'd0);

        // EN dropped during DATA of the first of two words
        w[0] = 4'($urandom);
        w[1] = 4'($urandom);
        push(0, w[0]);
        push(0, w[1]);
        wait_rd(0);
        check_frame(0, w[0], 1, 8);
        chk("endrop_rd_end", 32'(rd0), 32'd0);
        chk("endrop_busy_end", 32'(busy0), 32'd0);
        rd_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rd0) rd_seen++;
        end
        chk("endrop_no_rd", 32'(rd_seen), 32'd0);
        chk("endrop_empty", 32'(empty0), 32'd0);
        en0 = 1'b1;
        wait_rd(0);
        check_frame(0, w[1], 1, -1);

        // Reset pulsed mid-DATA
        w[0] = 4'($urandom);
        w[1] = 4'($urandom);
        push(0, w[0]);
        push(0, w[1]);
        wait_rd(0);
        repeat (10) @(negedge clk);
        chk("midrst_pre_busy", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx0), 32'd1);
        chk("midrst_rd", 32'(rd0), 32'd0);
        chk("midrst_busy", 32'(busy0), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_restart_rd", 32'(rd0), 32'd1);
        wait_rd(0);
        check_frame(0, w[1], 1, -1);
        chk("midrst_busy_end", 32'(busy0), 32'd0);

        // EMPTY held with EN=1
        rd_seen = 0;
        tx_low = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rd0) rd_seen++;
            if (!tx0) tx_low++;
        end
        chk("empty_no_rd", 32'(rd_seen), 32'd0);
        chk("empty_tx_high", 32'(tx_low), 32'd0);
        chk("empty_busy", 32'(busy0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
